// File: rtl/nor_gate_sweep_checker.sv
// Sweeps a three-input gate through all {a,b,c} combinations and checks d/e against expected truth tables.
// Optional macro SWEEP_GRAY_ORDER_EN: drive combinations in Gray order instead of binary order.
module nor_gate_sweep_checker #(
    parameter int          HOLD_CYCLES = 10,
    parameter int          SAMPLE_DLY  = 8,
    parameter logic [7:0]  EXP_D       = 8'b0000_0001,
    parameter logic [7:0]  EXP_E       = 8'b0000_0001
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       d,
    input  logic       e,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] fail_vec
);

    // state | meaning
    // IDLE  | waiting for start, gate inputs parked at 000
    // RUN   | applying combinations, sampling d/e once per combination
    // DONE  | one-cycle completion pulse, pass is valid
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] step, step_nxt;
    logic [7:0] hold_cnt, hold_nxt;
    logic [3:0] err_nxt;
    logic [7:0] fail_nxt;
    logic       pass_nxt;
    logic [2:0] seq;
    logic [2:0] abc;
    logic       mismatch;

`ifdef SWEEP_GRAY_ORDER_EN
    assign seq = step ^ (step >> 1);
`else
    assign seq = step;
`endif

    assign abc  = (state == RUN) ? seq : 3'b000;
    assign a    = abc[2];
    assign b    = abc[1];
    assign c    = abc[0];
    assign busy = (state == RUN);
    assign done = (state == DONE);

    // Simulation treats X/Z on the gate outputs as a failure; hardware uses plain equality.
`ifndef SYNTHESIS
    assign mismatch = (d !== EXP_D[abc]) || (e !== EXP_E[abc]);
`else
    assign mismatch = (d != EXP_D[abc]) || (e != EXP_E[abc]);
`endif

    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        hold_nxt  = hold_cnt;
        err_nxt   = err_count;
        fail_nxt  = fail_vec;
        pass_nxt  = pass;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    step_nxt  = 3'd0;
                    hold_nxt  = 8'd0;
                    err_nxt   = 4'd0;
                    fail_nxt  = 8'd0;
                    pass_nxt  = 1'b0;
                end
            end
            RUN: begin
                hold_nxt = hold_cnt + 8'd1;
                if (hold_cnt == 8'(SAMPLE_DLY) && mismatch) begin
                    fail_nxt[abc] = 1'b1;
                    err_nxt       = err_count + 4'd1;
                end
                if (hold_cnt == 8'(HOLD_CYCLES - 1)) begin
                    hold_nxt = 8'd0;
                    if (step == 3'd7) begin
                        state_nxt = DONE;
                        pass_nxt  = (err_nxt == 4'd0);
                    end else begin
                        step_nxt = step + 3'd1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            step      <= 3'd0;
            hold_cnt  <= 8'd0;
            err_count <= 4'd0;
            fail_vec  <= 8'd0;
            pass      <= 1'b0;
        end else begin
            state     <= state_nxt;
            step      <= step_nxt;
            hold_cnt  <= hold_nxt;
            err_count <= err_nxt;
            fail_vec  <= fail_nxt;
            pass      <= pass_nxt;
        end
    end

endmodule
